// File: rtl/lsu.sv
// Load/store stage between EXU and writeback: one data-memory transaction
// at a time on a req/ack port, aligned and size-extended load result out.
//
// Ports:
//   i_clk, i_rst             clock (rising edge), async active-high reset
//   i_sys_valid/o_sys_ready  upstream handshake (accept when both high)
//   i_idu_ctr_ram_rd_en/wr_en/size  load/store control; size[2]=zero-extend
//   i_exu_res, i_gpr_rs2_data       effective address and store data
//   o_ram_req/we/addr/wdata/wstrb   data-memory request, held until ack
//   i_ram_ack, i_ram_rdata          memory completion and read word
//   o_sys_valid/i_sys_ready         downstream handshake to writeback
//   o_ram_res, o_lsu_misalign       result and misalignment flag
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sys_valid,
    output logic              o_sys_ready,
    input  logic              i_idu_ctr_ram_rd_en,
    input  logic              i_idu_ctr_ram_wr_en,
    input  logic [2:0]        i_idu_ctr_ram_size,
    input  logic [ADDR_W-1:0] i_exu_res,
    input  logic [DATA_W-1:0] i_gpr_rs2_data,
    output logic              o_ram_req,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic [3:0]        o_ram_wstrb,
    input  logic              i_ram_ack,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_sys_valid,
    input  logic              i_sys_ready,
    output logic [DATA_W-1:0] o_ram_res,
    output logic              o_lsu_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] res_q;
    logic [2:0]        size_q;
    logic              rd_q;
    logic              wr_q;
    logic              mis_q;

    logic              accept;
    logic              in_mem;
    logic              in_mis;
    logic              mis_raw;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_val;
    logic              sext;
    logic              wr_eff;

    assign accept = i_sys_valid && (state_q == IDLE);
    assign in_mem = i_idu_ctr_ram_rd_en || i_idu_ctr_ram_wr_en;

    // Byte accesses can never be misaligned; size 3 behaves as word.
    always_comb begin
        mis_raw = 1'b0;
        unique case (i_idu_ctr_ram_size[1:0])
            2'd0:    mis_raw = 1'b0;
            2'd1:    mis_raw = i_exu_res[0];
            default: mis_raw = (i_exu_res[1:0] != 2'b00);
        endcase
    end

    assign in_mis = in_mem && mis_raw;

    // Load extraction from the acked word, using the captured address.
    assign lane = i_ram_rdata >> {addr_q[1:0], 3'b000};
    assign sext = !size_q[2];

    always_comb begin
        load_val = '0;
        unique case (size_q[1:0])
            2'd0:    load_val = {{24{lane[7] & sext}}, lane[7:0]};
            2'd1:    load_val = {{16{lane[15] & sext}}, lane[15:0]};
            default: load_val = i_ram_rdata;
        endcase
    end

    // A load takes priority when both enables are set.
    assign wr_eff = wr_q && !rd_q;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_mem && !in_mis) begin
                        state_d = REQ;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            REQ: begin
                if (i_ram_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_sys_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured transaction and result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q <= '0;
            data_q <= '0;
            size_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            mis_q  <= 1'b0;
            res_q  <= '0;
        end else begin
            if (accept) begin
                addr_q <= i_exu_res;
                data_q <= i_gpr_rs2_data;
                size_q <= i_idu_ctr_ram_size;
                rd_q   <= i_idu_ctr_ram_rd_en;
                wr_q   <= i_idu_ctr_ram_wr_en;
                mis_q  <= in_mis;
                res_q  <= '0;
            end else if (state_q == REQ && i_ram_ack) begin
                res_q <= rd_q ? load_val : '0;
            end
        end
    end

    // Outputs: memory side only live in REQ, result side only in RESP,
    // so a reset drops everything without waiting for a clock edge.
    always_comb begin
        o_sys_ready    = (state_q == IDLE);
        o_ram_req      = 1'b0;
        o_ram_we       = 1'b0;
        o_ram_addr     = '0;
        o_ram_wdata    = '0;
        o_ram_wstrb    = 4'b0000;
        o_sys_valid    = 1'b0;
        o_ram_res      = '0;
        o_lsu_misalign = 1'b0;
        unique case (state_q)
            REQ: begin
                o_ram_req  = 1'b1;
                o_ram_we   = wr_eff;
                o_ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
                if (wr_eff) begin
                    unique case (size_q[1:0])
                        2'd0: begin
                            o_ram_wstrb = 4'b0001 << addr_q[1:0];
                            o_ram_wdata = {4{data_q[7:0]}};
                        end
                        2'd1: begin
                            o_ram_wstrb = 4'b0011 << addr_q[1:0];
                            o_ram_wdata = {2{data_q[15:0]}};
                        end
                        default: begin
                            o_ram_wstrb = 4'b1111;
                            o_ram_wdata = data_q;
                        end
                    endcase
                end
            end
            RESP: begin
                o_sys_valid    = 1'b1;
                o_ram_res      = res_q;
                o_lsu_misalign = mis_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed vector table, hand-written reset and
// back-pressure sequences, and random transactions against a model.
module tb_lsu;

    logic        i_clk;
    logic        i_rst;
    logic        i_sys_valid;
    logic        o_sys_ready;
    logic        i_idu_ctr_ram_rd_en;
    logic        i_idu_ctr_ram_wr_en;
    logic [2:0]  i_idu_ctr_ram_size;
    logic [31:0] i_exu_res;
    logic [31:0] i_gpr_rs2_data;
    logic        o_ram_req;
    logic        o_ram_we;
    logic [31:0] o_ram_addr;
    logic [31:0] o_ram_wdata;
    logic [3:0]  o_ram_wstrb;
    logic        i_ram_ack;
    logic [31:0] i_ram_rdata;
    logic        o_sys_valid;
    logic        i_sys_ready;
    logic [31:0] o_ram_res;
    logic        o_lsu_misalign;

    int checks;
    int failures;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_sys_valid        (i_sys_valid),
        .o_sys_ready        (o_sys_ready),
        .i_idu_ctr_ram_rd_en(i_idu_ctr_ram_rd_en),
        .i_idu_ctr_ram_wr_en(i_idu_ctr_ram_wr_en),
        .i_idu_ctr_ram_size (i_idu_ctr_ram_size),
        .i_exu_res          (i_exu_res),
        .i_gpr_rs2_data     (i_gpr_rs2_data),
        .o_ram_req          (o_ram_req),
        .o_ram_we           (o_ram_we),
        .o_ram_addr         (o_ram_addr),
        .o_ram_wdata        (o_ram_wdata),
        .o_ram_wstrb        (o_ram_wstrb),
        .i_ram_ack          (i_ram_ack),
        .i_ram_rdata        (i_ram_rdata),
        .o_sys_valid        (o_sys_valid),
        .i_sys_ready        (i_sys_ready),
        .o_ram_res          (o_ram_res),
        .o_lsu_misalign     (o_lsu_misalign)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rdat;
        int          ack_dly;
        int          rdy_dly;
        logic        req;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] res;
        logic        mis;
    } vec_t;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        unstable;
        logic        valid_seen;
        int          lat;
        logic [31:0] res;
        logic        mis;
        logic        rdy_busy;
        logic        back_idle;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [2:0] sz,
        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
        input int ack_dly, input int rdy_dly,
        input logic req, input logic we, input logic [3:0] strb,
        input logic [31:0] addr, input logic [31:0] wdata,
        input logic [31:0] res, input logic mis);
        vec_t v;
        v.rd = rd; v.wr = wr; v.sz = sz; v.a = a; v.d = d; v.rdat = rdat;
        v.ack_dly = ack_dly; v.rdy_dly = rdy_dly;
        v.req = req; v.we = we; v.strb = strb; v.addr = addr;
        v.wdata = wdata; v.res = res; v.mis = mis;
        return v;
    endfunction

    // Reference model from the access rules, using plain arithmetic.
    function automatic vec_t model(
        input logic rd, input logic wr, input logic [2:0] sz,
        input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat);
        vec_t e;
        int nb;
        int off;
        longint v;
        longint lim;
        e = mk(rd, wr, sz, a, d, rdat, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nb  = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        e.mis  = (rd || wr) && ((off % nb) != 0);
        e.req  = (rd || wr) && !e.mis;
        e.we   = e.req && wr && !rd;
        e.addr = a - 32'(off);
        if (e.we) begin
            e.strb = 4'(((1 << nb) - 1) << off);
            for (int i = 0; i < 4; i++)
                e.wdata[8*i +: 8] = 8'(d >> (8 * (i % nb)));
        end
        if (e.req && rd) begin
            lim = longint'(1) << (8 * nb);
            v = longint'(rdat >> (8 * off)) % lim;
            if (!sz[2] && v >= lim / 2)
                v = v + (longint'(1) << 32) - lim;
            e.res = v[31:0];
        end
        return e;
    endfunction

    task automatic do_txn(input vec_t v, output obs_t ob);
        int k;
        int w;
        ob = '{default: '0};
        @(negedge i_clk);
        chk("ready_before_accept", 32'(o_sys_ready), 32'd1);
        i_sys_valid         = 1'b1;
        i_idu_ctr_ram_rd_en = v.rd;
        i_idu_ctr_ram_wr_en = v.wr;
        i_idu_ctr_ram_size  = v.sz;
        i_exu_res           = v.a;
        i_gpr_rs2_data      = v.d;
        @(negedge i_clk);
        i_sys_valid    = 1'b0;
        i_exu_res      = $urandom;
        i_gpr_rs2_data = $urandom;
        k = 1;
        if (o_ram_req) begin
            ob.req   = 1'b1;
            ob.we    = o_ram_we;
            ob.strb  = o_ram_wstrb;
            ob.addr  = o_ram_addr;
            ob.wdata = o_ram_wdata;
            for (int j = 0; j < v.ack_dly; j++) begin
                @(negedge i_clk);
                k++;
                if (o_ram_req !== 1'b1 || o_ram_addr !== ob.addr ||
                    o_ram_we !== ob.we || o_ram_wstrb !== ob.strb ||
                    o_ram_wdata !== ob.wdata || o_sys_ready !== 1'b0)
                    ob.unstable = 1'b1;
            end
            i_ram_ack   = 1'b1;
            i_ram_rdata = v.rdat;
            @(negedge i_clk);
            k++;
            i_ram_ack   = 1'b0;
            i_ram_rdata = $urandom;
        end
        w = 0;
        while (!o_sys_valid && w < 20) begin
            @(negedge i_clk);
            k++;
            w++;
        end
        ob.valid_seen = o_sys_valid;
        ob.lat        = k;
        ob.res        = o_ram_res;
        ob.mis        = o_lsu_misalign;
        ob.rdy_busy   = o_sys_ready;
        for (int j = 0; j < v.rdy_dly; j++) begin
            i_ram_ack   = 1'($urandom);
            i_ram_rdata = $urandom;
            @(negedge i_clk);
            if (o_sys_valid !== 1'b1 || o_ram_res !== ob.res ||
                o_lsu_misalign !== ob.mis || o_sys_ready !== 1'b0 ||
                o_ram_req !== 1'b0)
                ob.unstable = 1'b1;
        end
        i_ram_ack   = 1'b0;
        i_sys_ready = 1'b1;
        @(negedge i_clk);
        i_sys_ready  = 1'b0;
        ob.back_idle = !o_sys_valid && o_sys_ready;
    endtask

    task automatic check_txn(input string tag, input vec_t v, input obs_t ob);
        int lat;
        lat = v.req ? 2 + v.ack_dly : 1;
        chk({tag, "_valid"}, 32'(ob.valid_seen), 32'd1);
        chk({tag, "_lat"}, 32'(ob.lat), 32'(lat));
        chk({tag, "_req"}, 32'(ob.req), 32'(v.req));
        chk({tag, "_res"}, ob.res, v.res);
        chk({tag, "_mis"}, 32'(ob.mis), 32'(v.mis));
        chk({tag, "_stable"}, 32'(ob.unstable), 32'd0);
        chk({tag, "_busy"}, 32'(ob.rdy_busy), 32'd0);
        chk({tag, "_idle"}, 32'(ob.back_idle), 32'd1);
        if (v.req) begin
            chk({tag, "_addr"}, ob.addr, v.addr);
            chk({tag, "_we"}, 32'(ob.we), 32'(v.we));
            chk({tag, "_strb"}, 32'(ob.strb), 32'(v.strb));
            if (v.we)
                chk({tag, "_wdata"}, ob.wdata, v.wdata);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, 32'(o_ram_req), 32'd0);
        chk({tag, "_we"}, 32'(o_ram_we), 32'd0);
        chk({tag, "_addr"}, o_ram_addr, 32'd0);
        chk({tag, "_wdata"}, o_ram_wdata, 32'd0);
        chk({tag, "_strb"}, 32'(o_ram_wstrb), 32'd0);
        chk({tag, "_valid"}, 32'(o_sys_valid), 32'd0);
        chk({tag, "_res"}, o_ram_res, 32'd0);
        chk({tag, "_mis"}, 32'(o_lsu_misalign), 32'd0);
        chk({tag, "_ready"}, 32'(o_sys_ready), 32'd1);
    endtask

    vec_t vecs[13];
    obs_t ob;
    vec_t rv;

    initial begin
        checks = 0;
        failures = 0;
        i_rst = 1'b1;
        i_sys_valid = 1'b0;
        i_idu_ctr_ram_rd_en = 1'b0;
        i_idu_ctr_ram_wr_en = 1'b0;
        i_idu_ctr_ram_size = 3'd0;
        i_exu_res = '0;
        i_gpr_rs2_data = '0;
        i_ram_ack = 1'b0;
        i_ram_rdata = '0;
        i_sys_ready = 1'b0;

        //        rd wr sz      a             d             rdat          ack rdy req we strb     addr          wdata         res           mis
        vecs[0]  = mk(1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 1, 0, 4'b0000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 0);
        vecs[1]  = mk(1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_0000, 3, 0, 1, 0, 4'b0000, 32'h0000_2000, 32'h0,        32'h0000_8001, 0);
        vecs[2]  = mk(0, 1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'h5555_5555, 0, 0, 1, 1, 4'b0010, 32'h0000_3000, 32'hABAB_ABAB, 32'h0,         0);
        vecs[3]  = mk(1, 0, 3'b010, 32'h0000_4002, 32'h0,        32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,         1);
        vecs[4]  = mk(0, 0, 3'b010, 32'h0000_5003, 32'h1234_5678, 32'h0,        0, 4, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,         0);
        vecs[5]  = mk(0, 1, 3'b001, 32'h0000_5002, 32'h1234_5678, 32'h0,        1, 1, 1, 1, 4'b1100, 32'h0000_5000, 32'h5678_5678, 32'h0,         0);
        vecs[6]  = mk(0, 1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,        2, 0, 1, 1, 4'b1111, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,         0);
        vecs[7]  = mk(1, 0, 3'b010, 32'h0000_7004, 32'h0,        32'hCAFE_F00D, 0, 2, 1, 0, 4'b0000, 32'h0000_7004, 32'h0,        32'hCAFE_F00D, 0);
        vecs[8]  = mk(1, 0, 3'b001, 32'h0000_8000, 32'h0,        32'h0000_9ABC, 0, 0, 1, 0, 4'b0000, 32'h0000_8000, 32'h0,        32'hFFFF_9ABC, 0);
        vecs[9]  = mk(1, 1, 3'b010, 32'h0000_9000, 32'h0000_0001, 32'h1122_3344, 0, 0, 1, 0, 4'b0000, 32'h0000_9000, 32'h0,        32'h1122_3344, 0);
        vecs[10] = mk(0, 1, 3'b001, 32'h0000_A001, 32'hFFFF_FFFF, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,         1);
        vecs[11] = mk(1, 0, 3'b011, 32'h0000_B002, 32'h0,        32'h0,         0, 0, 0, 0, 4'b0000, 32'h0,         32'h0,        32'h0,         1);
        vecs[12] = mk(1, 0, 3'b100, 32'h0000_C001, 32'h0,        32'h0000_F000, 0, 0, 1, 0, 4'b0000, 32'h0000_C000, 32'h0,        32'h0000_00F0, 0);

        #12;
        check_all_zero("reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 13; i++) begin
            do_txn(vecs[i], ob);
            check_txn($sformatf("vec%0d", i), vecs[i], ob);
        end

        // Reset in REQ: request must drop with no clock edge.
        @(negedge i_clk);
        i_sys_valid = 1'b1;
        i_idu_ctr_ram_rd_en = 1'b1;
        i_idu_ctr_ram_wr_en = 1'b0;
        i_idu_ctr_ram_size = 3'b010;
        i_exu_res = 32'h0000_D000;
        @(negedge i_clk);
        i_sys_valid = 1'b0;
        chk("mid_req_req", 32'(o_ram_req), 32'd1);
        chk("mid_req_ready", 32'(o_sys_ready), 32'd0);
        #1 i_rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(o_ram_req), 32'd0);
        chk("async_rst_ready", 32'(o_sys_ready), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("after_req_rst");

        // Reset in RESP: result is dropped.
        @(negedge i_clk);
        i_sys_valid = 1'b1;
        i_idu_ctr_ram_rd_en = 1'b0;
        @(negedge i_clk);
        i_sys_valid = 1'b0;
        chk("mid_resp_valid", 32'(o_sys_valid), 32'd1);
        #1 i_rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(o_sys_valid), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("after_resp_rst");

        for (int n = 0; n < 150; n++) begin
            logic rd;
            logic wr;
            logic [2:0] sz;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] rdat;
            rd = 1'($urandom);
            wr = 1'($urandom);
            sz = 3'($urandom);
            a = $urandom;
            d = $urandom;
            rdat = $urandom;
            rv = model(rd, wr, sz, a, d, rdat);
            rv.ack_dly = int'($urandom_range(0, 3));
            rv.rdy_dly = int'($urandom_range(0, 2));
            do_txn(rv, ob);
            check_txn($sformatf("rnd%0d", n), rv, ob);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store stage directly upstream of the writeback stage. Takes the EXU result as the memory address and rs2 data as store data.
- Runs one transaction at a time on a simple req/ack data-memory port.
- Presents the aligned, size-extended load value as o_ram_res to writeback under a valid/ready handshake.
- Non-memory instructions pass through in one cycle so writeback timing is uniform.

Parameters:
ADDR_W, 32, address width (matches `ADDR_WIDTH)
DATA_W, 32, data width (matches `DATA_WIDTH); the design is defined for 32 only

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_sys_valid  input  1  upstream (EXU) holds a valid instruction
o_sys_ready  output  1  LSU can accept an instruction
i_idu_ctr_ram_rd_en  input  1  instruction is a load
i_idu_ctr_ram_wr_en  input  1  instruction is a store
i_idu_ctr_ram_size  input  3  [1:0] 0=byte 1=half 2=word (3 illegal, treated as word); [2] 1=zero-extend
i_exu_res  input  ADDR_W  effective address
i_gpr_rs2_data  input  DATA_W  store data
o_ram_req  output  1  memory request
o_ram_we  output  1  1=write
o_ram_addr  output  ADDR_W  word-aligned address ({addr[31:2],2'b00})
o_ram_wdata  output  DATA_W  lane-replicated store data
o_ram_wstrb  output  4  byte strobes
i_ram_ack  input  1  memory completes the request this cycle
i_ram_rdata  input  DATA_W  read word, valid with ack
o_sys_valid  output  1  result valid to writeback
i_sys_ready  input  1  writeback accepts
o_ram_res  output  DATA_W  load result (0 for stores and non-memory instructions)
o_lsu_misalign  output  1  captured access was misaligned (valid with o_sys_valid)

Behaviour:
- States: IDLE, REQ, RESP. Reset forces IDLE asynchronously.
- Reset values: o_ram_req, o_ram_we, o_sys_valid, o_lsu_misalign = 0. o_ram_addr, o_ram_wdata, o_ram_wstrb, o_ram_res = 0.
- o_sys_ready = (state==IDLE). It is therefore 1 during and after reset.
- No overlap: o_sys_ready is 0 in REQ and RESP.
- Accept happens at a clock edge where i_sys_valid && o_sys_ready. At accept, the LSU captures address, data, size, sign, rd_en and wr_en.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0. A misaligned access goes to RESP with o_lsu_misalign=1 and o_ram_res=0. No memory request is issued.
- rd_en and wr_en both set: rd_en wins; no write is issued.
- Neither rd_en nor wr_en: go to RESP with o_ram_res=0.
- Aligned load or store: go to REQ.
- REQ state:
  - o_ram_req=1 and all o_ram_* held stable until i_ram_ack is sampled high.
  - o_ram_we = captured wr_en && !rd_en.
  - Store strobes: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
  - Store data: byte = {4{d[7:0]}}; half = {2{d[15:0]}}; word = d.
  - Loads drive wstrb=0.
  - On ack, the LSU goes to RESP and deasserts o_ram_req in that state.
- Load extraction at ack:
  - lane = i_ram_rdata >> (8*addr[1:0]).
  - byte = lane[7:0]; half = lane[15:0]; word = i_ram_rdata.
  - Sign-extend unless size[2]=1; then zero-extend.
  - Stores yield o_ram_res=0.
- RESP state: o_sys_valid=1, with o_ram_res and o_lsu_misalign held. When i_sys_ready is sampled high, the LSU goes to IDLE and o_sys_valid drops the next cycle.
- Latency (accept at edge T):
  - memory op with ack in the first REQ cycle: o_sys_valid high from T+2.
  - non-memory or misaligned: o_sys_valid high from T+1.
- i_ram_ack outside REQ is ignored.
- Ack wait is unbounded; there is no timeout.
- Reset mid-REQ: o_ram_req drops immediately and asynchronously, and the transaction is abandoned. The memory must tolerate an abandoned request.
- Reset mid-RESP: the result is lost and o_sys_valid=0.

Test Plan:
- Reset asserted mid-REQ → o_ram_req=0 and o_sys_ready=1 with no clock edge. After release, the LSU is idle and all outputs are 0.
- Load byte signed, addr=0x1003, rdata=0x80FF_1234, ack in the first REQ cycle → o_ram_addr=0x1000, wstrb=0, o_ram_res=0xFFFF_FF80, o_sys_valid at T+2.
- Load half unsigned, addr=0x2002, rdata=0x8001_0000, ack delayed 3 cycles → req and addr stable for 3 cycles, o_ram_res=0x0000_8001.
- Store byte, addr=0x3001, rs2=0x0000_00AB → o_ram_we=1, wstrb=4'b0010, wdata=0xABAB_ABAB, o_ram_res=0.
- Word load at addr=0x4002 → no o_ram_req, o_lsu_misalign=1, o_ram_res=0, o_sys_valid at T+1.
- Non-memory op with i_sys_ready held 0 for 4 cycles → o_sys_valid and o_ram_res=0 held, o_sys_ready=0 throughout. When i_sys_ready=1, the LSU returns to IDLE and accepts a new instruction on the next cycle.
